// File: rtl/minrv32_mem_pkg.sv
// Shared types and widths for the minrv32 memory-port arbiter.
package minrv32_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

   localparam int MEM_AW = 32;
   localparam int MEM_DW = 32;
   localparam int MEM_SW = 4;

endpackage

// File: rtl/minrv32_mem_watchdog.sv
// Per-transaction wait counter: cleared outside BUSY, counts stalled cycles, saturates at TIMEOUT.
module minrv32_mem_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic tick,
   output logic expire
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (tick && (cnt != LIMIT)) begin
         cnt <= cnt + CW'(1);
      end
   end

   // TIMEOUT == 0 disables the watchdog entirely
   assign expire = (TIMEOUT > 0) && (cnt == LIMIT);

endmodule

// File: rtl/minrv32_mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) onto a single picorv32-style memory port.
//  state  | meaning
//  IDLE   | no transaction; arbitrate and latch the winner's request
//  BUSY_I | fetch in flight, waiting for mem_ready or watchdog expiry
//  BUSY_D | load/store in flight, waiting for mem_ready or watchdog expiry
module minrv32_mem_arbiter
   import minrv32_mem_pkg::*;
#(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_valid,
   input  logic [MEM_AW-1:0] i_addr,
   output logic              i_ready,
   output logic [MEM_DW-1:0] i_rdata,
   input  logic              d_valid,
   input  logic [MEM_AW-1:0] d_addr,
   input  logic [MEM_DW-1:0] d_wdata,
   input  logic [MEM_SW-1:0] d_wstrb,
   output logic              d_ready,
   output logic [MEM_DW-1:0] d_rdata,
   output logic              mem_valid,
   output logic              mem_instr,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [MEM_DW-1:0] mem_wdata,
   output logic [MEM_SW-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic [MEM_DW-1:0] mem_rdata,
   output logic              timeout_err,
   output logic              err_sticky
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_e    state;
   logic [SW-1:0] streak;
   logic          busy;
   logic          expire;
   logic          done;
   logic          i_win;

   assign busy = (state != IDLE);

   minrv32_mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .resetn (resetn),
      .clear  (!busy),
      .tick   (busy && !mem_ready),
      .expire (expire)
   );

   assign done  = busy && (mem_ready || expire);
   assign i_win = i_valid && (!d_valid || (streak == STREAK_MAX));

   // A requester that withdrew its valid gets no ready; the transaction still retires
   assign i_ready     = (state == BUSY_I) && done && i_valid;
   assign d_ready     = (state == BUSY_D) && done && d_valid;
   assign i_rdata     = (i_ready && mem_ready) ? mem_rdata : '0;
   assign d_rdata     = (d_ready && mem_ready) ? mem_rdata : '0;
   assign timeout_err = busy && expire && !mem_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         streak     <= '0;
         mem_valid  <= 1'b0;
         mem_instr  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         err_sticky <= 1'b0;
      end else begin
         if (timeout_err) begin
            err_sticky <= 1'b1;
         end
         if (!i_valid) begin
            streak <= '0;
         end
         case (state)
            IDLE: begin
               if (i_win) begin
                  state     <= BUSY_I;
                  mem_valid <= 1'b1;
                  mem_instr <= 1'b1;
                  mem_addr  <= i_addr;
                  mem_wdata <= '0;
                  mem_wstrb <= '0;
                  streak    <= '0;
               end else if (d_valid) begin
                  state     <= BUSY_D;
                  mem_valid <= 1'b1;
                  mem_instr <= 1'b0;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_wstrb <= d_wstrb;
                  if (i_valid && (streak != STREAK_MAX)) begin
                     streak <= streak + SW'(1);
                  end
               end
            end
            default: begin
               if (done) begin
                  state     <= IDLE;
                  mem_valid <= 1'b0;
                  mem_instr <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minrv32_mem_arbiter.sv
// Directed bench for the minrv32 memory arbiter with a request scoreboard.
module tb_minrv32_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        i_valid;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_valid;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        timeout_err;
   logic        err_sticky;

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   req_t exp_q[$];

   minrv32_mem_arbiter #(
      .MAX_D_STREAK (4),
      .TIMEOUT      (64)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .i_valid     (i_valid),
      .i_addr      (i_addr),
      .i_ready     (i_ready),
      .i_rdata     (i_rdata),
      .d_valid     (d_valid),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_wstrb     (d_wstrb),
      .d_ready     (d_ready),
      .d_rdata     (d_rdata),
      .mem_valid   (mem_valid),
      .mem_instr   (mem_instr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .timeout_err (timeout_err),
      .err_sticky  (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
      req_t r;
      r.instr = instr;
      r.addr  = addr;
      r.wdata = wdata;
      r.wstrb = wstrb;
      exp_q.push_back(r);
   endtask

   // Waits for a new downstream issue (at most 'extra' cycles beyond the next one) and scores it.
   task automatic wait_issue(input int extra);
      int   n;
      req_t e;
      n = 0;
      @(negedge clk);
      while (mem_valid !== 1'b1 && n < extra) begin
         @(negedge clk);
         n++;
      end
      chk("issue_valid", mem_valid, 1);
      if (mem_valid === 1'b1) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_fails++;
            $error("FAIL sb_empty: observed issue addr %h, expected no issue", mem_addr);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("issue_instr", mem_instr, e.instr);
            chk("issue_addr", mem_addr, e.addr);
            chk("issue_wstrb", mem_wstrb, e.wstrb);
            if (!e.instr) chk("issue_wdata", mem_wdata, e.wdata);
         end
      end
   endtask

   // Answers the in-flight transaction after 'delay' cycles and checks the response routing.
   task automatic complete(input bit is_i, input int delay, input logic [31:0] rd, input bit drop);
      repeat (delay) @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = rd;
      #1;
      chk("i_ready", i_ready, is_i);
      chk("d_ready", d_ready, !is_i);
      chk("i_rdata", i_rdata, is_i ? rd : 32'h0);
      chk("d_rdata", d_rdata, is_i ? 32'h0 : rd);
      chk("timeout_err_normal", timeout_err, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      if (drop) begin
         if (is_i) i_valid = 1'b0;
         else      d_valid = 1'b0;
      end
      #1;
      chk("idle_gap", mem_valid, 0);
   endtask

   initial begin
      bit order [6] = '{0, 0, 0, 0, 1, 0};

      resetn    = 1'b0;
      i_valid   = 1'b0;
      i_addr    = 32'h0;
      d_valid   = 1'b0;
      d_addr    = 32'h0;
      d_wdata   = 32'h0;
      d_wstrb   = 4'h0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;

      repeat (3) @(negedge clk);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_instr", mem_instr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_err_sticky", err_sticky, 0);
      resetn = 1'b1;

      // mem_ready while idle must not produce a response
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("idle_ready_i", i_ready, 0);
      chk("idle_ready_d", d_ready, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("idle_ready_valid", mem_valid, 0);

      // Fetch only, answered two cycles after issue
      @(negedge clk);
      i_valid = 1'b1;
      i_addr  = 32'h0001_0000;
      push_req(1'b1, 32'h0001_0000, 32'h0, 4'h0);
      wait_issue(0);
      complete(1'b1, 2, 32'h0000_0013, 1'b1);

      // Simultaneous requests: store wins, fetch follows one idle cycle later
      @(negedge clk);
      i_valid = 1'b1;
      i_addr  = 32'h0001_0004;
      d_valid = 1'b1;
      d_addr  = 32'h0000_2000;
      d_wdata = 32'hDEAD_BEEF;
      d_wstrb = 4'hF;
      push_req(1'b0, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
      push_req(1'b1, 32'h0001_0004, 32'h0, 4'h0);
      wait_issue(0);
      complete(1'b0, 0, 32'h1111_2222, 1'b1);
      wait_issue(0);
      complete(1'b1, 1, 32'h3333_4444, 1'b1);

      // Both held high: four D grants, then a forced I grant, then D again
      @(negedge clk);
      i_valid = 1'b1;
      i_addr  = 32'h0002_0000;
      d_valid = 1'b1;
      d_addr  = 32'h0000_3000;
      d_wdata = 32'h0;
      d_wstrb = 4'h0;
      for (int g = 0; g < 6; g++) begin
         if (order[g]) push_req(1'b1, 32'h0002_0000, 32'h0, 4'h0);
         else          push_req(1'b0, 32'h0000_3000, 32'h0, 4'h0);
      end
      for (int g = 0; g < 6; g++) begin
         wait_issue(0);
         complete(order[g], 0, 32'hA000_0000 + 32'(g), 1'b0);
      end
      i_valid = 1'b0;
      d_valid = 1'b0;

      // Memory never answers: watchdog completes the load after 64 stalled cycles
      @(negedge clk);
      d_valid = 1'b1;
      d_addr  = 32'h0000_4000;
      d_wstrb = 4'h0;
      push_req(1'b0, 32'h0000_4000, 32'h0, 4'h0);
      wait_issue(0);
      mem_rdata = 32'h55AA_55AA;
      repeat (63) @(negedge clk);
      #1;
      chk("wd_early_ready", d_ready, 0);
      chk("wd_early_err", timeout_err, 0);
      @(negedge clk);
      #1;
      chk("wd_d_ready", d_ready, 1);
      chk("wd_d_rdata", d_rdata, 0);
      chk("wd_timeout_err", timeout_err, 1);
      @(negedge clk);
      d_valid   = 1'b0;
      mem_rdata = 32'h0;
      #1;
      chk("wd_mem_valid_drop", mem_valid, 0);
      chk("wd_err_pulse_end", timeout_err, 0);
      chk("wd_err_sticky", err_sticky, 1);

      // mem_ready lands exactly on the expiry cycle: normal completion
      @(negedge clk);
      d_valid = 1'b1;
      d_addr  = 32'h0000_5000;
      push_req(1'b0, 32'h0000_5000, 32'h0, 4'h0);
      wait_issue(0);
      repeat (63) @(negedge clk);
      #1;
      chk("race_early_ready", d_ready, 0);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      #1;
      chk("race_d_ready", d_ready, 1);
      chk("race_d_rdata", d_rdata, 32'hCAFE_F00D);
      chk("race_timeout_err", timeout_err, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      d_valid   = 1'b0;
      #1;
      chk("race_mem_valid", mem_valid, 0);
      chk("race_err_sticky_kept", err_sticky, 1);

      // Fetch withdrawn mid-flight: transaction retires without a ready pulse
      @(negedge clk);
      i_valid = 1'b1;
      i_addr  = 32'h0003_0000;
      push_req(1'b1, 32'h0003_0000, 32'h0, 4'h0);
      wait_issue(0);
      i_valid = 1'b0;
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_0077;
      #1;
      chk("wdrawn_i_ready", i_ready, 0);
      chk("wdrawn_i_rdata", i_rdata, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      #1;
      chk("wdrawn_mem_valid", mem_valid, 0);

      // Reset while a load is in flight
      @(negedge clk);
      d_valid = 1'b1;
      d_addr  = 32'h0000_6000;
      push_req(1'b0, 32'h0000_6000, 32'h0, 4'h0);
      wait_issue(0);
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("arst_mem_valid", mem_valid, 0);
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_d_ready", d_ready, 0);
      chk("arst_err_sticky", err_sticky, 0);
      d_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      i_valid = 1'b1;
      i_addr  = 32'h0004_0000;
      push_req(1'b1, 32'h0004_0000, 32'h0, 4'h0);
      wait_issue(0);
      complete(1'b1, 1, 32'h0000_0093, 1'b1);

      chk("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
